// File: rtl/mdu_pkg.sv
// mdu_pkg: MDUOp encodings, state type and default latencies for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [3:0] {
    OP_NONE  = 4'b0000,
    OP_MULT  = 4'b0001,
    OP_MULTU = 4'b0010,
    OP_DIV   = 4'b0011,
    OP_DIVU  = 4'b0100,
    OP_MFHI  = 4'b0101,
    OP_MFLO  = 4'b0110,
    OP_MTHI  = 4'b0111,
    OP_MTLO  = 4'b1000
  } mdu_op_e;
  typedef enum logic {IDLE, RUN} mdu_state_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit {hi,lo} for mult/multu/div/divu plus divide-by-zero flag
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  mdu_op_e     op,
  output logic [63:0] res,
  output logic        div_zero
);
  logic s, na, nb, dz, is_mul;
  logic [31:0] ua, ub, q, r, qs, rs;
  logic [63:0] prod;
  assign s = (op == OP_MULT) || (op == OP_DIV);
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign prod = {{32{s & in_a[31]}}, in_a} * {{32{s & in_b[31]}}, in_b};
  // Signed divide on magnitudes: INT_MIN/-1 then naturally yields 0x80000000 rem 0
  assign na = s & in_a[31];
  assign nb = s & in_b[31];
  assign ua = na ? -in_a : in_a;
  assign ub = nb ? -in_b : in_b;
  assign dz = in_b == 32'd0;
  assign q  = ua / (dz ? 32'd1 : ub);
  assign r  = ua % (dz ? 32'd1 : ub);
  assign qs = (na ^ nb) ? -q : q;
  assign rs = na ? -r : r;
  assign res = is_mul ? prod : {rs, qs};
  assign div_zero = dz && !is_mul;
endmodule

// File: rtl/mdu.sv
// mdu: HI/LO owner with busy-counter latency emulation for the EX-stage multiply/divide unit
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  input  logic        req,
  output logic        busy,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  mdu_op_e op;
  mdu_state_e st;
  logic [CW-1:0] count, count_n;
  logic [31:0] ph, pl, hi_n, lo_n;
  logic pdz, dz, accept, mt_ok, commit, is_md, is_mul;
  logic [63:0] res;
  assign op = mdu_op_e'(MDUOp);
  mdu_arith u_arith (.in_a(in_a), .in_b(in_b), .op(op), .res(res), .div_zero(dz));
  assign st = (count == '0) ? IDLE : RUN;
  assign is_md = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign accept = (st == IDLE) && start && !req && is_md;
  assign mt_ok = (st == IDLE) && !req;
  assign commit = count == CW'(1);
  always_comb begin
    count_n = accept ? (is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES))
                     : (st == IDLE) ? '0 : count - CW'(1);
    hi_n = (commit && !pdz) ? ph : (mt_ok && op == OP_MTHI) ? in_a : hi;
    lo_n = (commit && !pdz) ? pl : (mt_ok && op == OP_MTLO) ? in_a : lo;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      ph    <= '0;
      pl    <= '0;
      pdz   <= 1'b0;
    end else begin
      count <= count_n;
      hi    <= hi_n;
      lo    <= lo_n;
      if (accept) begin
        {ph, pl} <= res;
        pdz      <= dz;
      end
    end
  end
  assign busy = st == RUN;
  assign result = (op == OP_MFHI) ? hi : (op == OP_MFLO) ? lo : 32'd0;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: table-driven and hand-sequenced self-checking bench for mdu
module tb_mdu;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, req = 1'b0, busy;
  logic [31:0] in_a = '0, in_b = '0, result, hi, lo;
  logic [3:0] MDUOp = 4'd0;
  int errors = 0, checks = 0;
  localparam logic [31:0] PRE_HI = 32'hAAAA5555, PRE_LO = 32'h5555AAAA;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, ehi, elo;
    int          cyc;
  } vec_t;
  vec_t v[9];

  mdu dut (.clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .MDUOp(MDUOp),
           .start(start), .req(req), .busy(busy), .result(result), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MDUOp = op; in_a = a; in_b = b; start = 1'b1;
    @(negedge clk);
    MDUOp = 4'd0; start = 1'b0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    MDUOp = op; in_a = a;
    @(negedge clk);
    MDUOp = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    v[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    v[1] = '{4'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    v[2] = '{4'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    v[3] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    v[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    v[5] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    v[6] = '{4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    v[7] = '{4'd4, 32'd5,        32'd0,        PRE_HI,       PRE_LO,       10};
    v[8] = '{4'd3, 32'hFFFFFFFB, 32'd0,        PRE_HI,       PRE_LO,       10};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    MDUOp = 4'd5;
    #1 chk("reset_mfhi", result, 32'd0);

    for (int i = 0; i < 9; i++) begin
      mt(4'd7, PRE_HI);
      mt(4'd8, PRE_LO);
      issue(v[i].op, v[i].a, v[i].b);
      wait_idle(n);
      chk($sformatf("v%0d_cycles", i), n, v[i].cyc);
      chk($sformatf("v%0d_hi", i), hi, v[i].ehi);
      chk($sformatf("v%0d_lo", i), lo, v[i].elo);
      MDUOp = 4'd5;
      #1 chk($sformatf("v%0d_mfhi", i), result, v[i].ehi);
      MDUOp = 4'd6;
      #1 chk($sformatf("v%0d_mflo", i), result, v[i].elo);
      MDUOp = 4'd0;
      #1 chk($sformatf("v%0d_none", i), result, 32'd0);
    end

    // start together with req is dropped; then mthi
    mt(4'd7, 32'h0);
    mt(4'd8, 32'h0);
    @(negedge clk);
    MDUOp = 4'd1; in_a = 32'd9; in_b = 32'd9; start = 1'b1; req = 1'b1;
    @(negedge clk);
    MDUOp = 4'd0; start = 1'b0; req = 1'b0;
    chk("req_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    chk("req_hi", hi, 32'd0);
    chk("req_lo", lo, 32'd81 & 32'd0);
    mt(4'd7, 32'h1234);
    chk("mthi_hi", hi, 32'h1234);
    MDUOp = 4'd5;
    #1 chk("mthi_mfhi", result, 32'h1234);
    MDUOp = 4'd0;

    // mthi blocked by req
    @(negedge clk);
    MDUOp = 4'd7; in_a = 32'h5678; req = 1'b1;
    @(negedge clk);
    MDUOp = 4'd0; req = 1'b0;
    chk("mthi_req_hi", hi, 32'h1234);

    // start with a non-mult/div op is ignored
    @(negedge clk);
    MDUOp = 4'd6; start = 1'b1;
    @(negedge clk);
    MDUOp = 4'd0; start = 1'b0;
    chk("badop_busy", {31'd0, busy}, 32'd0);

    // mt and start while busy are ignored; divide by zero keeps HI/LO
    mt(4'd7, PRE_HI);
    mt(4'd8, PRE_LO);
    issue(4'd4, 32'd5, 32'd0);
    MDUOp = 4'd7; in_a = 32'hDEAD;
    @(negedge clk);
    MDUOp = 4'd1; in_a = 32'd2; in_b = 32'd3; start = 1'b1;
    @(negedge clk);
    MDUOp = 4'd0; start = 1'b0;
    wait_idle(n);
    chk("busy_ign_cycles", n + 2, 32'd10);
    chk("busy_ign_hi", hi, PRE_HI);
    chk("busy_ign_lo", lo, PRE_LO);

    // req mid-operation does not cancel
    issue(4'd2, 32'd6, 32'd7);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_idle(n);
    chk("req_mid_cycles", n + 1, 32'd5);
    chk("req_mid_hi", hi, 32'd0);
    chk("req_mid_lo", lo, 32'd42);

    // reset in third busy cycle
    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    repeat (2) @(negedge clk);
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    repeat (8) @(negedge clk);
    chk("rst_late_hi", hi, 32'd0);
    chk("rst_late_lo", lo, 32'd0);
    chk("rst_late_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
